seq_mul: RTL and testbench
==========================

Name: seq_mul

Overview:
Parametrised iterative shift-add multiplier with a start/ready/done handshake and a per-operation signed/unsigned mode. It computes one WIDTH x WIDTH product in WIDTH+1 cycles using a single WIDTH-bit adder, and holds the full 2*WIDTH-bit product until the next completion. It serves as the area-lean multiply unit for datapaths where multi-cycle latency is acceptable.

Parameters:
WIDTH, 32, operand width in bits; must be >= 2; the product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not to be overridden.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous and active-high.
start  in  1  request a new multiply; accepted only when ready=1.
is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
a  in  WIDTH  multiplicand; sampled when start is accepted.
b  in  WIDTH  multiplier; sampled when start is accepted.
ready  out  1  high in IDLE; the unit can accept start.
done  out  1  single-cycle pulse when result is updated.
result  out  2*WIDTH  product; stable between done pulses.

Behaviour:
- One clock (clk); reset is asynchronous, active-high (rst). Reset mid-operation aborts immediately.
- Reset values: state=IDLE, ready=1, done=0, result=0, internal accumulator/counter=0.
- States: IDLE, RUN, FIX.
- IDLE: ready=1. start=1 at an edge -> capture |a| and |b| (magnitudes when is_signed=1, raw values otherwise), neg = is_signed & (a[W-1]^b[W-1]), acc={WIDTH zeros, |b|}, cnt=WIDTH -> RUN.
- RUN (ready=0): each cycle, if acc[0], upper half += |a| using a WIDTH-bit adder with carry-out. Then acc = {carry, upper sum, acc[W-1:1]}, a logical right shift by 1. cnt decrements; at cnt==1 -> FIX. RUN lasts exactly WIDTH cycles.
- FIX: result = neg ? -acc : acc (two's complement over 2*WIDTH bits). done=1 for this one cycle. -> IDLE.
- Latency: start sampled at edge N; done=1 and new result valid during cycle N+WIDTH+1. Earliest next start is accepted at edge N+WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles.
- start while ready=0 is ignored and not queued. start in the FIX cycle is also ignored.
- Operands are registered at accept; changes on a/b/is_signed during RUN have no effect.
- Magnitude of the most-negative value, -2^(W-1), is 2^(W-1) and fits in WIDTH unsigned bits. No overflow is possible; the full product always fits in 2*WIDTH bits.
- A zero operand still takes the full WIDTH cycles. There is no early termination.
- result is never cleared except by rst; it is overwritten only in FIX.
- rst asserted during RUN or FIX: outputs return to reset values asynchronously. The in-flight operation is discarded and no done is produced.

Decomposition:
- Shared package mul_pkg: state enum (IDLE, RUN, FIX); helper function abs_val(width-generic magnitude).
- One sub-module: adder_n, a parametrised WIDTH-bit ripple/behavioural adder with Cin/Cout. It is the generalisation of the existing fixed-width adder and is instantiated once for the RUN accumulate.
- Everything else, including sign fix-up negation and the counter, stays in seq_mul.

Test Plan:
- WIDTH=32, unsigned a=3, b=5, start pulse -> done exactly 33 cycles after the accept edge, result=0x000000000000000F, ready returns 1 next cycle.
- Unsigned a=b=0xFFFFFFFF -> result=0xFFFFFFFE00000001 (exercises carry-out every step).
- Signed cases -> expected result:
  - a=0xFFFFFFF9 (-7), b=3 -> 0xFFFFFFFFFFFFFFEB.
  - a=b=0x80000000 -> 0x4000000000000000.
  - a=b=0xFFFFFFFF -> 1.
- Start pulses at cycles 5 and 20 after an accept, with different a/b and a toggled during RUN -> only the first operation completes, with its original operands; a single done pulse is observed.
- rst asserted asynchronously mid-cycle at RUN iteration 10 -> ready=1, done=0, result=0 immediately with no clock edge; a following 6x7 produces 42.
- WIDTH=8 instance, randomized 1000 operations in both modes versus a reference model -> all match; done interval is exactly 9 cycles from accept.

Source files
------------

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and helpers for the sequential multiplier
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Widest operand abs_val can handle; callers extend to this width and cast back.
    localparam int MAX_W = 128;

    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v, input logic neg);
        return neg ? (~v + MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/adder_n.sv
// rtl/adder_n.sv - parametrised WIDTH-bit adder with carry-in and carry-out
module adder_n #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - iterative shift-add multiplier, signed/unsigned, WIDTH+1 cycle latency
module seq_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    state_t             state, next_state;
    logic [WIDTH-1:0]   mag_a;
    logic [2*WIDTH-1:0] acc;
    logic               neg;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_abs, b_abs, addend, sum;
    logic               cout;

    assign a_abs  = WIDTH'(abs_val(MAX_W'(a), is_signed & a[WIDTH-1]));
    assign b_abs  = WIDTH'(abs_val(MAX_W'(b), is_signed & b[WIDTH-1]));
    assign addend = acc[0] ? mag_a : '0;
    assign ready  = (state == IDLE);

    adder_n #(.WIDTH(WIDTH)) u_adder (
        .a    (acc[2*WIDTH-1:WIDTH]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (cnt == CNT_W'(1)) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // done and result are registered together so they always appear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_a  <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a <= a_abs;
                        neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc   <= {{WIDTH{1'b0}}, b_abs};
                        cnt   <= CNT_W'(WIDTH);
                    end
                end
                RUN: begin
                    acc <= {cout, sum, acc[WIDTH-1:1]};
                    cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    result <= neg ? (~acc + (2*WIDTH)'(1)) : acc;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// tb/tb_seq_mul.sv - self-checking bench for seq_mul at WIDTH=32 and WIDTH=8
module tb_seq_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        st32, sg32, st8, sg8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        ready32, done32, ready8, done8;
    logic [63:0] res32;
    logic [15:0] res8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_mul #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(st32), .is_signed(sg32),
        .a(a32), .b(b32), .ready(ready32), .done(done32), .result(res32)
    );

    seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .is_signed(sg8),
        .a(a8), .b(b8), .ready(ready8), .done(done8), .result(res8)
    );

    // Drives one 32-bit operation from a negedge; lat counts cycles from the accept edge to done.
    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [63:0] res, output int lat);
        int guard = 0;
        while (!ready32 && guard < 100) begin @(negedge clk); guard++; end
        a32 = a; b32 = b; sg32 = s; st32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st32 = 1'b0;
        lat = 0;
        while (!done32 && lat < 100) begin @(negedge clk); lat++; end
        res = res32;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic [15:0] res, output int lat);
        int guard = 0;
        while (!ready8 && guard < 100) begin @(negedge clk); guard++; end
        a8 = a; b8 = b; sg8 = s; st8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 100) begin @(negedge clk); lat++; end
        res = res8;
    endtask

    function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = 64'(a);
        ub = 64'(b);
        return ua * ub;
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int x, y;
        x = s ? int'($signed(a)) : int'(a);
        y = s ? int'($signed(b)) : int'(b);
        return 16'(x * y);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks += 3;
        if (ready32 !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready32); end
        if (done32 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done32); end
        if (res32 !== 64'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", res32); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_ready8 got %b want 1", ready8); end
        if (res8 !== 16'd0) begin n_fail++; $display("FAIL reset_result8 got %h want 0", res8); end
    endtask

    task automatic test_unsigned_basic();
        logic [63:0] r;
        int lat;
        op32(32'd3, 32'd5, 1'b0, r, lat);
        n_checks += 2;
        if (r !== 64'h0000_0000_0000_000F) begin n_fail++; $display("FAIL u3x5_result got %h want %h", r, 64'hF); end
        if (lat != 33) begin n_fail++; $display("FAIL u3x5_latency got %0d want 33", lat); end
        @(negedge clk);
        n_checks += 2;
        if (ready32 !== 1'b1) begin n_fail++; $display("FAIL u3x5_ready_after got %b want 1", ready32); end
        if (done32 !== 1'b0) begin n_fail++; $display("FAIL u3x5_done_pulse_width got %b want 0", done32); end
    endtask

    task automatic test_unsigned_max();
        logic [63:0] r;
        int lat;
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL umax_result got %h want FFFFFFFE00000001", r); end
    endtask

    task automatic test_signed();
        logic [31:0] ta[3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] tb[3] = '{32'd3,         32'h8000_0000, 32'hFFFF_FFFF};
        logic [63:0] te[3] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000, 64'd1};
        logic [63:0] r;
        int lat;
        for (int i = 0; i < 3; i++) begin
            op32(ta[i], tb[i], 1'b1, r, lat);
            n_checks++;
            if (r !== te[i]) begin n_fail++; $display("FAIL signed_case%0d got %h want %h", i, r, te[i]); end
        end
    endtask

    task automatic test_ignored_start();
        int dones = 0;
        int first_lat = -1;
        logic [63:0] got = '0;
        a32 = 32'd1234; b32 = 32'd5678; sg32 = 1'b0; st32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st32 = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (done32) begin
                dones++;
                if (first_lat < 0) begin first_lat = k; got = res32; end
            end
            st32 = (k == 5 || k == 20);
            if (k == 5)  begin a32 = 32'd9;  b32 = 32'd11; end
            if (k == 10) a32 = ~a32;
            if (k == 20) begin a32 = 32'd77; b32 = 32'd88; sg32 = 1'b1; end
            @(negedge clk);
        end
        st32 = 1'b0;
        n_checks += 3;
        if (dones != 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", dones); end
        if (first_lat != 33) begin n_fail++; $display("FAIL ignore_latency got %0d want 33", first_lat); end
        if (got !== 64'd7006652) begin n_fail++; $display("FAIL ignore_result got %h want %h", got, 64'd7006652); end
    endtask

    task automatic test_async_reset();
        logic [63:0] r;
        int lat;
        int seen_done = 0;
        a32 = 32'd100; b32 = 32'd200; sg32 = 1'b0; st32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st32 = 1'b0;
        for (int k = 0; k < 10; k++) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks += 3;
        if (ready32 !== 1'b1) begin n_fail++; $display("FAIL async_rst_ready got %b want 1", ready32); end
        if (done32 !== 1'b0) begin n_fail++; $display("FAIL async_rst_done got %b want 0", done32); end
        if (res32 !== 64'd0) begin n_fail++; $display("FAIL async_rst_result got %h want 0", res32); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done32) seen_done++;
            @(negedge clk);
        end
        n_checks++;
        if (seen_done != 0) begin n_fail++; $display("FAIL async_rst_spurious_done got %0d want 0", seen_done); end
        op32(32'd6, 32'd7, 1'b0, r, lat);
        n_checks += 2;
        if (r !== 64'd42) begin n_fail++; $display("FAIL after_rst_6x7 got %h want 42", r); end
        if (lat != 33) begin n_fail++; $display("FAIL after_rst_latency got %0d want 33", lat); end
    endtask

    task automatic test_random8();
        logic [7:0]  ra, rb;
        logic        rs;
        logic [15:0] r, exp;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = 8'h80; rb = 8'h80; rs = 1'b1; end
            if (i == 1) begin ra = 8'h00; rb = 8'hFF; rs = 1'b0; end
            if (i == 2) begin ra = 8'hFF; rb = 8'hFF; rs = 1'b0; end
            exp = model8(ra, rb, rs);
            op8(ra, rb, rs, r, lat);
            n_checks += 2;
            if (r !== exp) begin n_fail++; $display("FAIL rand8_%0d a=%h b=%h s=%b got %h want %h", i, ra, rb, rs, r, exp); end
            if (lat != 9) begin n_fail++; $display("FAIL rand8_latency_%0d got %0d want 9", i, lat); end
        end
    endtask

    task automatic test_random32();
        logic [31:0] ra, rb;
        logic        rs;
        logic [63:0] r, exp;
        int lat;
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            exp = model32(ra, rb, rs);
            op32(ra, rb, rs, r, lat);
            n_checks++;
            if (r !== exp) begin n_fail++; $display("FAIL rand32_%0d a=%h b=%h s=%b got %h want %h", i, ra, rb, rs, r, exp); end
        end
    endtask

    initial begin
        st32 = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;
        st8  = 1'b0; sg8  = 1'b0; a8  = '0; b8  = '0;
        test_reset();
        test_unsigned_basic();
        test_unsigned_max();
        test_signed();
        test_ignored_start();
        test_async_reset();
        test_random32();
        test_random8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
